gf_track_formatter: RTL and testbench
=====================================

Name: gf_track_formatter

Overview:
- Parametrised track/end-event formatter with integrated output datapath.
- Pops a type stream, a parallel track-record FIFO and an end-event FIFO. Serialises each track into NWORDS words of WIDTH bits into the output FIFO, and appends the end-event word with EP/EE flags.
- Adds per-word backpressure stalling, a per-event track counter and optional truncation at MAX_TRACKS.
- Sits between the track-fit output FIFOs and the output link FIFO.

Parameters:
WIDTH, 32, output word width (bits)
NWORDS, 7, words per track record (2..16)
CNT_W, 8, width of track counter
MAX_TRACKS, 255, tracks allowed per event before truncation (< 2**CNT_W)
TRUNCATE, 1, 1 = drop tracks beyond MAX_TRACKS; 0 = never drop, counter saturates

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  reset
TYPE_EMPTY  in  1  type FIFO empty
TYPE_DATA  in  1  FWFT head of type FIFO: 0 = track, 1 = end event; valid when !TYPE_EMPTY
TYPE_RE  out  1  pop type FIFO
TRACK_EMPTY  in  1  track FIFO empty
TRACK_DATA  in  NWORDS*WIDTH  FWFT track record; word k = bits [k*WIDTH +: WIDTH], word 0 sent first
TRACK_RE  out  1  pop track FIFO
EE_EMPTY  in  1  end-event FIFO empty
EE_DATA  in  WIDTH  FWFT end-event word
EE_RE  out  1  pop end-event FIFO
OUT_FULL  in  1  output FIFO full
OUT_WE  out  1  output FIFO write
OUT_DATA  out  WIDTH  output word
OUT_EP  out  1  end-of-packet flag (last word of track, or EE word)
OUT_EE  out  1  end-of-event flag
TRACK_COUNT  out  CNT_W  tracks written in current event
OVERFLOW  out  1  tracks dropped in current event (sticky until EE written)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (RESET_N). While low: state IDLE, word index 0, TRACK_COUNT 0, OVERFLOW 0. All RE/WE outputs are combinational from state and are therefore 0.
- States: IDLE, TRACK, ENDEV, DROP. Word index idx is 0..NWORDS-1.
- IDLE decision, taken when !TYPE_EMPTY:
  - TYPE_DATA=0 and !TRACK_EMPTY, with TRUNCATE=1 and TRACK_COUNT>=MAX_TRACKS -> DROP.
  - TYPE_DATA=0 and !TRACK_EMPTY, otherwise -> TRACK with idx=0.
  - TYPE_DATA=1 and !EE_EMPTY -> ENDEV.
  - Otherwise stay in IDLE. No output activity in IDLE.
- TRACK:
  - OUT_WE = !OUT_FULL.
  - OUT_DATA = word idx of TRACK_DATA.
  - OUT_EP = (idx==NWORDS-1) & OUT_WE; OUT_EE = 0.
  - On write: idx increments.
  - On write of the last word: TRACK_RE=1 and TYPE_RE=1 in the same cycle; TRACK_COUNT increments, saturating at 2**CNT_W-1; -> IDLE.
  - OUT_FULL high: hold state and idx; no write, no pop. Stall may occur at any word without loss or duplication.
- ENDEV:
  - OUT_WE = !OUT_FULL.
  - OUT_DATA = EE_DATA with bit WIDTH-1 replaced by EE_DATA[WIDTH-1] | OVERFLOW.
  - OUT_EP = OUT_EE = OUT_WE.
  - On write: EE_RE=1, TYPE_RE=1, TRACK_COUNT<=0, OVERFLOW<=0, -> IDLE.
- DROP: TRACK_RE=1, TYPE_RE=1, OVERFLOW<=1, no write; -> IDLE next cycle. Never waits on OUT_FULL.
- Throughput: a track of NWORDS words takes NWORDS+1 cycles without stalls (1 IDLE decision cycle). EE takes 2 cycles. Drop takes 2 cycles.
- OUT_DATA/OUT_EP/OUT_EE are don't-care when OUT_WE=0 but must not be X; drive 0.
- RE outputs never assert while the corresponding EMPTY is high. Violation is a bench assertion failure.
- Reset asserted mid-track: the partial track is abandoned with no pop, so the record is re-sent after reset; counters clear.

Test Plan:
- NWORDS=7, one track record (words 0x10..0x16), OUT_FULL=0 -> 7 consecutive OUT_WE cycles with data 0x10..0x16; OUT_EP only on 0x16; TRACK_RE and TYPE_RE single pulse on that cycle; TRACK_COUNT=1.
- Two tracks then EE_DATA=0x0000_00AB -> 15 writes; last word 0x0000_00AB with OUT_EP=OUT_EE=1; EE_RE pulse; TRACK_COUNT returns to 0.
- OUT_FULL high for 4 cycles while idx=3 -> no OUT_WE during stall; word 3 written on first cycle OUT_FULL=0; sequence 0x10..0x16 intact, no duplicates.
- MAX_TRACKS=2, TRUNCATE=1, 3 tracks + EE_DATA=0x5 -> 14 track writes; third record popped in DROP with no write; OVERFLOW=1; EE word = 0x8000_0005; OVERFLOW cleared after.
- TYPE_DATA=1 with EE_EMPTY=1 for 10 cycles -> stays IDLE, no RE/WE; EE arrives -> ENDEV write next cycle.
- RESET_N pulled low asynchronously at idx=4 -> outputs 0 immediately; after release, the same record is re-sent from word 0.

Source files
------------

// File: rtl/gf_track_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : gf_track_formatter
//  Purpose  : Serialises FWFT track records into NWORDS output words and
//             appends the end-event word with EP/EE flags. Counts tracks per
//             event, optionally drops tracks beyond MAX_TRACKS and flags the
//             drop in the MSB of the end-event word.
//  Revision : 1.0  initial release
// ============================================================================
module gf_track_formatter #(
    parameter int WIDTH      = 32,
    parameter int NWORDS     = 7,
    parameter int CNT_W      = 8,
    parameter int MAX_TRACKS = 255,
    parameter int TRUNCATE   = 1
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic                    TYPE_EMPTY,
    input  logic                    TYPE_DATA,
    output logic                    TYPE_RE,
    input  logic                    TRACK_EMPTY,
    input  logic [NWORDS*WIDTH-1:0] TRACK_DATA,
    output logic                    TRACK_RE,
    input  logic                    EE_EMPTY,
    input  logic [WIDTH-1:0]        EE_DATA,
    output logic                    EE_RE,
    input  logic                    OUT_FULL,
    output logic                    OUT_WE,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic                    OUT_EP,
    output logic                    OUT_EE,
    output logic [CNT_W-1:0]        TRACK_COUNT,
    output logic                    OVERFLOW
);

    localparam int               IDX_W  = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_TRACKS);
    localparam logic [CNT_W-1:0] C_SAT  = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_ENDEV = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_trunc;
    logic             w_last;
    logic [WIDTH-1:0] w_word;

    // Drop decision: only when truncation is enabled and the event is full
    assign w_trunc = (TRUNCATE != 0) && (r_count >= C_MAX);
    assign w_last  = (r_idx == C_LAST);

    // Select the current track word from the flat record
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_word = TRACK_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    // State register; asynchronous reset abandons any partial track
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!TYPE_EMPTY) begin
                    if (!TYPE_DATA) begin
                        if (!TRACK_EMPTY) begin
                            w_next = w_trunc ? S_DROP : S_TRACK;
                        end
                    end else if (!EE_EMPTY) begin
                        w_next = S_ENDEV;
                    end
                end
            end
            S_TRACK: begin
                if (!OUT_FULL && w_last) begin
                    w_next = S_IDLE;
                end
            end
            S_ENDEV: begin
                if (!OUT_FULL) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are purely a function of state and inputs; idle lines stay at 0
    always_comb begin
        TYPE_RE  = 1'b0;
        TRACK_RE = 1'b0;
        EE_RE    = 1'b0;
        OUT_WE   = 1'b0;
        OUT_DATA = '0;
        OUT_EP   = 1'b0;
        OUT_EE   = 1'b0;
        case (r_state)
            S_TRACK: begin
                OUT_WE = !OUT_FULL;
                if (!OUT_FULL) begin
                    OUT_DATA = w_word;
                    OUT_EP   = w_last;
                    TRACK_RE = w_last;
                    TYPE_RE  = w_last;
                end
            end
            S_ENDEV: begin
                OUT_WE = !OUT_FULL;
                if (!OUT_FULL) begin
                    OUT_DATA = {EE_DATA[WIDTH-1] | r_ovf, EE_DATA[WIDTH-2:0]};
                    OUT_EP   = 1'b1;
                    OUT_EE   = 1'b1;
                    EE_RE    = 1'b1;
                    TYPE_RE  = 1'b1;
                end
            end
            S_DROP: begin
                TRACK_RE = 1'b1;
                TYPE_RE  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Word index, per-event track counter and sticky overflow flag
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idx   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                end
                S_TRACK: begin
                    if (!OUT_FULL) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (r_count != C_SAT) begin
                                r_count <= r_count + CNT_W'(1);
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_ENDEV: begin
                    if (!OUT_FULL) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_ovf <= 1'b1;
                end
            endcase
        end
    end

    assign TRACK_COUNT = r_count;
    assign OVERFLOW    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gf_track_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf_track_formatter
//  Purpose  : Directed scoreboard bench for gf_track_formatter with
//             MAX_TRACKS=2 so truncation is reachable with short events.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gf_track_formatter;

    localparam int W  = 32;
    localparam int NW = 7;
    localparam int CW = 8;

    logic              CLOCK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              TYPE_EMPTY, TYPE_DATA, TYPE_RE;
    logic              TRACK_EMPTY, TRACK_RE;
    logic [NW*W-1:0]   TRACK_DATA;
    logic              EE_EMPTY, EE_RE;
    logic [W-1:0]      EE_DATA;
    logic              OUT_FULL = 1'b0;
    logic              OUT_WE, OUT_EP, OUT_EE, OVERFLOW;
    logic [W-1:0]      OUT_DATA;
    logic [CW-1:0]     TRACK_COUNT;

    gf_track_formatter #(
        .WIDTH(W), .NWORDS(NW), .CNT_W(CW), .MAX_TRACKS(2), .TRUNCATE(1)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .TYPE_EMPTY(TYPE_EMPTY), .TYPE_DATA(TYPE_DATA), .TYPE_RE(TYPE_RE),
        .TRACK_EMPTY(TRACK_EMPTY), .TRACK_DATA(TRACK_DATA), .TRACK_RE(TRACK_RE),
        .EE_EMPTY(EE_EMPTY), .EE_DATA(EE_DATA), .EE_RE(EE_RE),
        .OUT_FULL(OUT_FULL), .OUT_WE(OUT_WE), .OUT_DATA(OUT_DATA),
        .OUT_EP(OUT_EP), .OUT_EE(OUT_EE),
        .TRACK_COUNT(TRACK_COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    // Simple FWFT FIFO models: writers are the stimulus, readers the DUT
    logic            type_mem [0:63];
    logic [NW*W-1:0] trk_mem  [0:63];
    logic [W-1:0]    ee_mem   [0:63];
    int type_wr = 0, type_rd = 0, trk_wr = 0, trk_rd = 0, ee_wr = 0, ee_rd = 0;

    assign TYPE_EMPTY  = (type_wr == type_rd);
    assign TYPE_DATA   = type_mem[type_rd[5:0]];
    assign TRACK_EMPTY = (trk_wr == trk_rd);
    assign TRACK_DATA  = trk_mem[trk_rd[5:0]];
    assign EE_EMPTY    = (ee_wr == ee_rd);
    assign EE_DATA     = ee_mem[ee_rd[5:0]];

    always @(posedge CLOCK) begin
        if (TYPE_RE)  type_rd <= type_rd + 1;
        if (TRACK_RE) trk_rd  <= trk_rd + 1;
        if (EE_RE)    ee_rd   <= ee_rd + 1;
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         ep;
        logic         ee;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;

    // Monitor: compare every output write against the scoreboard head
    always @(negedge CLOCK) begin
        exp_t e;
        if (RESET_N) begin
            if ((TYPE_RE && TYPE_EMPTY) || (TRACK_RE && TRACK_EMPTY) || (EE_RE && EE_EMPTY)) begin
                errors++;
                $display("FAIL re_on_empty type=%0b/%0b track=%0b/%0b ee=%0b/%0b",
                         TYPE_RE, TYPE_EMPTY, TRACK_RE, TRACK_EMPTY, EE_RE, EE_EMPTY);
            end
            if (OUT_WE && OUT_FULL) begin
                errors++;
                $display("FAIL we_while_full actual=1 required=0");
            end
            if (OUT_WE) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write data=%h ep=%0b ee=%0b", OUT_DATA, OUT_EP, OUT_EE);
                end else begin
                    e = exp_q.pop_front();
                    if (OUT_DATA !== e.d || OUT_EP !== e.ep || OUT_EE !== e.ee) begin
                        errors++;
                        $display("FAIL out_word actual=%h ep=%0b ee=%0b required=%h ep=%0b ee=%0b",
                                 OUT_DATA, OUT_EP, OUT_EE, e.d, e.ep, e.ee);
                    end
                    checks++;
                    if (TYPE_RE !== e.ep || TRACK_RE !== (e.ep & ~e.ee) || EE_RE !== e.ee) begin
                        errors++;
                        $display("FAIL pop_pulses actual type=%0b track=%0b ee=%0b required type=%0b track=%0b ee=%0b",
                                 TYPE_RE, TRACK_RE, EE_RE, e.ep, e.ep & ~e.ee, e.ee);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Queue a track record; nexp = how many of its words to expect on output
    task automatic push_track(input logic [W-1:0] base, input int nexp);
        logic [NW*W-1:0] rec;
        exp_t e;
        for (int k = 0; k < NW; k++) begin
            rec[k*W +: W] = base + W'(k);
            if (k < nexp) begin
                e.d = base + W'(k); e.ep = (k == NW-1); e.ee = 1'b0;
                exp_q.push_back(e);
            end
        end
        trk_mem[trk_wr[5:0]] = rec;
        trk_wr++;
        type_mem[type_wr[5:0]] = 1'b0;
        type_wr++;
    endtask

    task automatic push_ee_data(input logic [W-1:0] d, input logic [W-1:0] req);
        exp_t e;
        e.d = req; e.ep = 1'b1; e.ee = 1'b1;
        exp_q.push_back(e);
        ee_mem[ee_wr[5:0]] = d;
        ee_wr++;
    endtask

    task automatic push_type_ee();
        type_mem[type_wr[5:0]] = 1'b1;
        type_wr++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (n == 200) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        for (n = 0; n < 100; n++) begin
            if (wr_cnt >= target) break;
            tick();
        end
        if (n == 100) begin
            errors++;
            $display("FAIL %s_timeout writes=%0d required=%0d", name, wr_cnt, target);
        end
    endtask

    initial begin
        int base_w, base_t, base_trk;

        // Reset state
        #2;
        chk("rst_we", W'(OUT_WE), 0);
        chk("rst_count", W'(TRACK_COUNT), 0);
        chk("rst_ovf", W'(OVERFLOW), 0);
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();

        // One track 0x10..0x16
        push_track(32'h10, NW);
        wait_drain("t1");
        chk("t1_count", W'(TRACK_COUNT), 1);
        chk("t1_trk_pops", W'(trk_rd), 1);
        chk("t1_type_pops", W'(type_rd), 1);

        // Second track of same event, then end event 0xAB
        push_track(32'h20, NW);
        push_ee_data(32'h0000_00AB, 32'h0000_00AB);
        push_type_ee();
        wait_drain("t2");
        chk("t2_total_writes", W'(wr_cnt), 15);
        chk("t2_ee_pops", W'(ee_rd), 1);
        chk("t2_count_clear", W'(TRACK_COUNT), 0);

        // Stall for 4 cycles at word 3
        base_w = wr_cnt;
        push_track(32'h10, NW);
        wait_writes(base_w + 3, "t3");
        OUT_FULL = 1'b1;
        repeat (4) tick();
        chk("t3_stall_writes", W'(wr_cnt), W'(base_w + 3));
        OUT_FULL = 1'b0;
        wait_drain("t3");
        chk("t3_count", W'(TRACK_COUNT), 1);
        push_ee_data(32'h0000_0001, 32'h0000_0001);
        push_type_ee();
        wait_drain("t3e");

        // Truncation: third track of event dropped, overflow flagged in EE
        base_w = wr_cnt;
        base_trk = trk_rd;
        push_track(32'h30, NW);
        push_track(32'h40, NW);
        push_track(32'h50, 0);
        wait_drain("t4");
        repeat (3) tick();
        chk("t4_writes", W'(wr_cnt - base_w), 14);
        chk("t4_trk_pops", W'(trk_rd - base_trk), 3);
        chk("t4_ovf", W'(OVERFLOW), 1);
        chk("t4_count", W'(TRACK_COUNT), 2);
        push_ee_data(32'h0000_0005, 32'h8000_0005);
        push_type_ee();
        wait_drain("t4e");
        chk("t4_ovf_clear", W'(OVERFLOW), 0);
        chk("t4_count_clear", W'(TRACK_COUNT), 0);

        // End-event type with empty EE FIFO must wait quietly
        base_w = wr_cnt;
        base_t = type_rd;
        push_type_ee();
        repeat (10) tick();
        chk("t5_no_write", W'(wr_cnt), W'(base_w));
        chk("t5_no_pop", W'(type_rd), W'(base_t));
        push_ee_data(32'h0000_0033, 32'h0000_0033);
        tick();
        tick();
        chk("t5_ee_latency", W'(exp_q.size()), 0);
        wait_drain("t5");

        // Asynchronous reset in the middle of a track
        base_w = wr_cnt;
        base_trk = trk_rd;
        push_track(32'h60, 4);
        wait_writes(base_w + 4, "t6");
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_we", W'(OUT_WE), 0);
        chk("t6_rst_trk_re", W'(TRACK_RE), 0);
        chk("t6_rst_count", W'(TRACK_COUNT), 0);
        chk("t6_pending", W'(exp_q.size()), 0);
        for (int k = 0; k < NW; k++) begin
            exp_t e;
            e.d = 32'h60 + W'(k); e.ep = (k == NW-1); e.ee = 1'b0;
            exp_q.push_back(e);
        end
        tick();
        chk("t6_no_pop_in_reset", W'(trk_rd), W'(base_trk));
        RESET_N = 1'b1;
        wait_drain("t6");
        chk("t6_trk_pops", W'(trk_rd - base_trk), 1);
        chk("t6_count", W'(TRACK_COUNT), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
